// File: rtl/axi_wr_burst_sched.sv
// Round-robin arbiter sharing one AXI4 write master between NUM_CH video write channels.
// Issues one burst at a time, generates per-channel frame-buffer addresses and tracks frame progress.
module axi_wr_burst_sched #(
    parameter int          NUM_CH                     = 2,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 128,
    parameter int          C_M_AXI_BURST_LEN          = 16,
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
    parameter logic [31:0] CH_STRIDE                  = 32'h01000000,
    parameter int          FRAME_BURSTS               = 10800,
    parameter int          CNT_W                      = 10,
    localparam int         CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic [NUM_CH-1:0]             ch_frame_start,
    input  logic [NUM_CH*CNT_W-1:0]       ch_fifo_cnt,
    output logic                          burst_req,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] burst_addr,
    output logic [CH_W-1:0]               burst_ch,
    input  logic                          burst_ack,
    input  logic                          burst_done,
    output logic [NUM_CH-1:0]             ch_frame_done,
    output logic [1:0]                    state_dbg
);

    localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
    localparam int BCNT_W      = $clog2(FRAME_BURSTS + 1);
    localparam int AW          = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   rr_ptr;
    logic [BCNT_W-1:0] burst_cnt [NUM_CH];
    logic [BCNT_W-1:0] cnt_after [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] granted;
    logic [NUM_CH-1:0] inc;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   scan_idx;
    logic [AW-1:0]     grant_addr;
    logic              done_evt;

    assign state_dbg = state;

    // Handshake: burst_req/burst_addr/burst_ch stay stable from rise until the cycle burst_ack is
    // sampled high; burst_done completes the single outstanding burst (same cycle as ack allowed).
    assign done_evt = burst_done && ((state == WAIT) || (state == REQ && burst_ack));

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            eligible[ch]  = (32'(ch_fifo_cnt[ch*CNT_W +: CNT_W]) >= 32'(C_M_AXI_BURST_LEN)) &&
                            (burst_cnt[ch] < BCNT_W'(FRAME_BURSTS)) && !ch_frame_start[ch];
            granted[ch]   = (state != IDLE) && (burst_ch == CH_W'(ch));
            inc[ch]       = (state == REQ) && burst_ack && granted[ch];
            cnt_after[ch] = burst_cnt[ch] + BCNT_W'(inc[ch]);
        end
    end

    // First eligible channel at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (!grant_valid && eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_ch    = scan_idx;
            end
        end
    end

    assign grant_addr = AW'(C_M_TARGET_SLAVE_BASE_ADDR)
                      + AW'(grant_ch) * AW'(CH_STRIDE)
                      + AW'(burst_cnt[grant_ch]) * AW'(BURST_BYTES);

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = REQ;
            REQ:     if (burst_ack)   state_nxt = burst_done ? IDLE : WAIT;
            WAIT:    if (burst_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            burst_req     <= 1'b0;
            burst_addr    <= '0;
            burst_ch      <= '0;
            ch_frame_done <= '0;
            rr_ptr        <= '0;
            pend          <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) burst_cnt[ch] <= '0;
        end else begin
            ch_frame_done <= '0;
            if (state == IDLE && grant_valid) begin
                burst_req  <= 1'b1;
                burst_ch   <= grant_ch;
                burst_addr <= grant_addr;
                rr_ptr     <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
            end
            if (state == REQ && burst_ack) burst_req <= 1'b0;

            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ch_frame_start[ch] && !granted[ch]) begin
                    burst_cnt[ch] <= '0;
                end else if (granted[ch] && done_evt) begin
                    // A frame restart seen during the burst wins over completion reporting.
                    if (pend[ch] || ch_frame_start[ch]) begin
                        burst_cnt[ch] <= '0;
                        pend[ch]      <= 1'b0;
                    end else begin
                        burst_cnt[ch] <= cnt_after[ch];
                        if (cnt_after[ch] == BCNT_W'(FRAME_BURSTS)) ch_frame_done[ch] <= 1'b1;
                    end
                end else begin
                    burst_cnt[ch] <= cnt_after[ch];
                    if (granted[ch] && ch_frame_start[ch]) pend[ch] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Self-checking bench for axi_wr_burst_sched: a responder plays the write master and compares
// every granted burst against an expected queue filled as each scenario is driven.
module tb_axi_wr_burst_sched;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 1;
    localparam int AW     = 32;
    localparam int CNT_W  = 10;
    localparam int EW     = CH_W + AW;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       ch_frame_start = '0;
    logic [NUM_CH*CNT_W-1:0] ch_fifo_cnt = '0;
    logic                    burst_req;
    logic [AW-1:0]           burst_addr;
    logic [CH_W-1:0]         burst_ch;
    logic                    burst_ack = 1'b0;
    logic                    burst_done = 1'b0;
    logic [NUM_CH-1:0]       ch_frame_done;
    logic [1:0]              state_dbg;

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            fd_cnt [NUM_CH];

    axi_wr_burst_sched #(
        .NUM_CH       (NUM_CH),
        .FRAME_BURSTS (4)
    ) dut (
        .M_AXI_ACLK     (clk),
        .M_AXI_ARESET   (rst),
        .ch_frame_start (ch_frame_start),
        .ch_fifo_cnt    (ch_fifo_cnt),
        .burst_req      (burst_req),
        .burst_addr     (burst_addr),
        .burst_ch       (burst_ch),
        .burst_ack      (burst_ack),
        .burst_done     (burst_done),
        .ch_frame_done  (ch_frame_done),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NUM_CH; i++) fd_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (ch_frame_done[i]) fd_cnt[i] = fd_cnt[i] + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_frame_start = '0;
        burst_ack = 1'b0;
        burst_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_fifo(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
        ch_fifo_cnt = {c1, c0};
    endtask

    function automatic logic [AW-1:0] exp_addr(input int ch, input int n);
        return 32'h10000000 + 32'(ch) * 32'h01000000 + 32'(n) * 32'h100;
    endfunction

    task automatic push_exp(input int ch, input int n);
        exp_q.push_back({CH_W'(ch), exp_addr(ch, n)});
    endtask

    task automatic wait_req(output logic got);
        int n;
        n = 0;
        while (!burst_req && n < 50) begin
            tick();
            n++;
        end
        got = burst_req;
        if (!got) check_eq("req_timeout", 64'(burst_req), 64'(1));
    endtask

    // write-master driver: gap < 0 gives ack and done in the same cycle
    task automatic serve_burst(input int gap, input logic fs_wait);
        logic          got;
        logic [EW-1:0] e;
        wait_req(got);
        if (!got) return;
        if (exp_q.size() == 0) begin
            check_eq("exp_underflow", 64'(exp_q.size()), 64'(1));
            return;
        end
        e = exp_q.pop_front();
        check_eq("burst_ch", 64'(burst_ch), 64'(e[EW-1 -: CH_W]));
        check_eq("burst_addr", 64'(burst_addr), 64'(e[AW-1:0]));
        tick();
        check_eq("req_hold", 64'(burst_req), 64'(1));
        check_eq("addr_hold", 64'(burst_addr), 64'(e[AW-1:0]));
        burst_ack = 1'b1;
        if (gap < 0) burst_done = 1'b1;
        tick();
        burst_ack = 1'b0;
        burst_done = 1'b0;
        check_eq("req_drop", 64'(burst_req), 64'(0));
        if (gap >= 0) begin
            if (fs_wait) begin
                ch_frame_start[e[EW-1 -: CH_W]] = 1'b1;
                tick();
                ch_frame_start = '0;
            end
            repeat (gap) tick();
            burst_done = 1'b1;
            tick();
            burst_done = 1'b0;
        end
    endtask

    initial begin
        int   viol;
        logic got;

        // 1: reset values, then idle with empty FIFOs
        tick();
        check_eq("rst_req", 64'(burst_req), 64'(0));
        check_eq("rst_addr", 64'(burst_addr), 64'(0));
        check_eq("rst_ch", 64'(burst_ch), 64'(0));
        check_eq("rst_fd", 64'(ch_frame_done), 64'(0));
        check_eq("rst_state", 64'(state_dbg), 64'(0));
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (burst_req || burst_addr != '0 || burst_ch != '0 || ch_frame_done != '0) viol++;
        end
        check_eq("idle_quiet", 64'(viol), 64'(0));

        // 2: single channel, latency and address increment
        do_reset();
        set_fifo(16, 0);
        tick();
        check_eq("req_latency", 64'(burst_req), 64'(1));
        push_exp(0, 0);
        push_exp(0, 1);
        serve_burst(0, 1'b0);
        serve_burst(2, 1'b0);
        set_fifo(0, 0);

        // 3: both channels alternate
        do_reset();
        set_fifo(16, 16);
        push_exp(0, 0);
        push_exp(1, 0);
        push_exp(0, 1);
        push_exp(1, 1);
        for (int i = 0; i < 4; i++) serve_burst(i % 2, 1'b0);
        set_fifo(0, 0);

        // 4: frame completion, no further grants, restart by frame_start
        do_reset();
        set_fifo(16, 0);
        for (int n = 0; n < 4; n++) push_exp(0, n);
        serve_burst(0, 1'b0);
        serve_burst(-1, 1'b0);
        serve_burst(1, 1'b0);
        serve_burst(0, 1'b0);
        tick();
        check_eq("frame_done_ch0", 64'(fd_cnt[0]), 64'(1));
        check_eq("frame_done_ch1", 64'(fd_cnt[1]), 64'(0));
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (burst_req) viol++;
        end
        check_eq("full_no_req", 64'(viol), 64'(0));
        check_eq("full_state", 64'(state_dbg), 64'(0));
        ch_frame_start = 2'b01;
        tick();
        ch_frame_start = '0;
        push_exp(0, 0);
        serve_burst(0, 1'b0);
        set_fifo(0, 0);
        tick();
        check_eq("single_pulse", 64'(fd_cnt[0]), 64'(1));

        // 5: frame_start during WAIT of burst #2 rewinds with no frame_done
        do_reset();
        set_fifo(16, 0);
        push_exp(0, 0);
        push_exp(0, 1);
        push_exp(0, 0);
        serve_burst(0, 1'b0);
        serve_burst(1, 1'b1);
        serve_burst(0, 1'b0);
        set_fifo(0, 0);
        tick();
        check_eq("pend_no_fd", 64'(fd_cnt[0]), 64'(1));

        // 6: asynchronous reset while in REQ
        do_reset();
        set_fifo(16, 16);
        wait_req(got);
        check_eq("pre_rst_ch", 64'(burst_ch), 64'(0));
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_rst_req", 64'(burst_req), 64'(0));
        check_eq("async_rst_state", 64'(state_dbg), 64'(0));
        tick();
        rst = 1'b0;
        push_exp(0, 0);
        serve_burst(0, 1'b0);
        set_fifo(0, 0);

        tick();
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
